// File: rtl/int_to_float.sv
// int_to_float
// Multi-cycle converter from a signed 32-bit two's-complement integer to an
// IEEE-754 single-precision value, rounded to nearest, ties to even. It has
// one conversion in flight and a stb/ack handshake on both sides, so it can
// drive an input port of the floating-point adder directly.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous, active-high reset
//   input_a       signed integer operand
//   input_a_stb   upstream: input_a is valid
//   input_a_ack   block is ready to accept input_a
//   output_z      IEEE-754 single result
//   output_z_stb  output_z is valid and is held stable while high
//   output_z_ack  downstream accepts output_z
module int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        CONVERT_0,
        CONVERT_1,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t state, state_nxt;
    logic   ack_nxt, stb_nxt;

    logic signed [31:0] a;
    logic        [31:0] value;     // unsigned magnitude, shifted left until bit 31 is set
    logic signed [9:0]  z_e;       // unbiased exponent
    logic        [23:0] z_m;       // mantissa including the hidden bit
    logic               z_s;
    logic               guard;
    logic               round_bit;
    logic               sticky;
    logic        [31:0] z;

    // Round to nearest, ties to even: increment when more than half an ulp
    // is discarded, or exactly half and the kept mantissa is odd.
    function automatic logic round_up(input logic g, input logic r,
                                      input logic s, input logic lsb);
        return g & (r | s | lsb);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            state        <= state_nxt;
            input_a_ack  <= ack_nxt;
            output_z_stb <= stb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = input_a_ack;
        stb_nxt   = output_z_stb;
        case (state)
            GET_A: begin
                ack_nxt = 1'b1;
                if (input_a_ack && input_a_stb) begin
                    ack_nxt   = 1'b0;
                    state_nxt = CONVERT_0;
                end
            end
            CONVERT_0: state_nxt = (a == 32'sd0) ? PUT_Z : CONVERT_1;
            CONVERT_1: state_nxt = NORMALISE;
            NORMALISE: if (value[31]) state_nxt = ROUND;
            ROUND:     state_nxt = PACK;
            PACK:      state_nxt = PUT_Z;
            PUT_Z: begin
                stb_nxt = 1'b1;
                // The handshake only completes once stb is already visible,
                // so an early ack from downstream is ignored.
                if (output_z_stb && output_z_ack) begin
                    stb_nxt   = 1'b0;
                    state_nxt = GET_A;
                end
            end
            default:   state_nxt = GET_A;
        endcase
    end

    // Datapath registers carry no reset; the control path alone decides
    // when their contents are meaningful.
    always_ff @(posedge clk) begin
        case (state)
            GET_A: begin
                if (input_a_ack && input_a_stb) a <= input_a;
            end
            CONVERT_0: begin
                if (a == 32'sd0) begin
                    z <= 32'h0000_0000;
                end else begin
                    z_s <= a[31];
                    // -(-2^31) wraps back to 0x80000000, which is the
                    // correct unsigned magnitude 2^31.
                    value <= a[31] ? $unsigned(-a) : $unsigned(a);
                end
            end
            CONVERT_1: z_e <= 10'sd31;
            NORMALISE: begin
                if (!value[31]) begin
                    value <= value << 1;
                    z_e   <= z_e - 10'sd1;
                end else begin
                    z_m       <= value[31:8];
                    guard     <= value[7];
                    round_bit <= value[6];
                    sticky    <= |value[5:0];
                end
            end
            ROUND: begin
                if (round_up(guard, round_bit, sticky, z_m[0])) begin
                    z_m <= z_m + 24'd1;
                    // Mantissa overflow: 1.111..1 rounds up to 10.000..0,
                    // and the wrapped zero mantissa is correct once the
                    // exponent steps up.
                    if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
                end
            end
            PACK: z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
            PUT_Z: output_z <= z;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_to_float.sv
// Testbench for int_to_float: directed corner cases, back-pressure, reset
// behaviour and randomized operands checked against an arithmetic reference.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int n_checks = 0;
    int n_fail   = 0;

    int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Position of the most significant set bit of the magnitude.
    function automatic int msb_pos(input longint m);
        int p = 0;
        for (int i = 0; i < 33; i++) if (m >= (longint'(1) << i)) p = i;
        return p;
    endfunction

    function automatic longint magnitude(input logic [31:0] v);
        longint u = longint'({32'b0, v});
        return v[31] ? (longint'(1) << 32) - u : u;
    endfunction

    // Reference: integer -> single precision with plain arithmetic,
    // round to nearest, ties to even.
    function automatic logic [31:0] model_f(input logic [31:0] v);
        longint m, q, rem, half;
        int     p, sh;
        if (v == 32'd0) return 32'd0;
        m = magnitude(v);
        p = msb_pos(m);
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {v[31], 8'(p + 127), q[22:0]};
    endfunction

    function automatic int lat_model(input logic [31:0] v);
        if (v == 32'd0) return 2;
        return 6 + (31 - msb_pos(magnitude(v)));
    endfunction

    // One full transaction: offer val, measure latency, optionally stall
    // the output for 'hold' cycles, then complete the output handshake.
    task automatic convert(input logic [31:0] val, input int hold,
                           output logic [31:0] res, output int lat);
        int          waited;
        logic [31:0] held;
        res = 32'hDEAD_BEEF;
        lat = -1;
        @(negedge clk);
        input_a     = val;
        input_a_stb = 1'b1;
        waited      = 0;
        while (!input_a_ack && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!input_a_ack) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            input_a_stb = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        input_a     = $urandom;
        lat = 0;
        while (!output_z_stb && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!output_z_stb) begin
            check_eq("result_timeout", 32'd0, 32'd1);
            return;
        end
        res  = output_z;
        held = output_z;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_eq("bp_z_stable", output_z, held);
            check_eq("bp_stb_high", 32'(output_z_stb), 32'd1);
            check_eq("bp_in_ack_low", 32'(input_a_ack), 32'd0);
        end
        @(negedge clk);
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
        check_eq("stb_drop", 32'(output_z_stb), 32'd0);
        check_eq("in_ack_low_on_return", 32'(input_a_ack), 32'd0);
        @(posedge clk);
        #1;
        check_eq("in_ack_rise", 32'(input_a_ack), 32'd1);
    endtask

    logic [31:0] dir_in  [10] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000,
                                  32'h7FFF_FFFF, 32'h8000_0000, 32'd16777217,
                                  32'd16777219, 32'd16777221, 32'd16777223, 32'd100};
    logic [31:0] dir_exp [10] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                                  32'h4F00_0000, 32'hCF00_0000, 32'h4B80_0000,
                                  32'h4B80_0002, 32'h4B80_0002, 32'h4B80_0004, 32'h42C8_0000};

    initial begin
        logic [31:0] res;
        logic [31:0] v;
        int          lat;
        int          waited;
        logic        seen;

        // Reset with a request already pending: no transfer may happen
        // until input_a_ack has been registered high.
        rst          = 1'b1;
        input_a      = 32'd7;
        input_a_stb  = 1'b1;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ack", 32'(input_a_ack), 32'd0);
        check_eq("rst_out_stb", 32'(output_z_stb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("first_get_a_ack", 32'(input_a_ack), 32'd1);
        convert(32'd7, 0, res, lat);
        check_eq("val_7", res, 32'h40E0_0000);
        check_eq("lat_7", 32'(lat), 32'(lat_model(32'd7)));

        // Directed values with their known encodings.
        for (int i = 0; i < 10; i++) begin
            convert(dir_in[i], 0, res, lat);
            check_eq($sformatf("dir_%08h", dir_in[i]), res, dir_exp[i]);
            check_eq($sformatf("dir_model_%08h", dir_in[i]), res, model_f(dir_in[i]));
            check_eq($sformatf("lat_%08h", dir_in[i]), 32'(lat), 32'(lat_model(dir_in[i])));
        end
        convert(32'd1, 0, res, lat);
        check_eq("lat_one_37", 32'(lat), 32'd37);
        convert(32'd0, 0, res, lat);
        check_eq("lat_zero_2", 32'(lat), 32'd2);

        // Output stalled for 20 cycles.
        convert(32'd12345, 20, res, lat);
        check_eq("bp_value", res, model_f(32'd12345));

        // Randomized operands spread over all magnitudes.
        for (int i = 0; i < 30; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            convert(v, 0, res, lat);
            check_eq($sformatf("rnd_%08h", v), res, model_f(v));
            check_eq($sformatf("rnd_lat_%08h", v), 32'(lat), 32'(lat_model(v)));
        end

        // Reset while normalising input 1: the result must never appear.
        @(negedge clk);
        input_a     = 32'd1;
        input_a_stb = 1'b1;
        waited      = 0;
        while (!input_a_ack && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("midrst_accept", 32'(input_a_ack), 32'd1);
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_in_ack", 32'(input_a_ack), 32'd0);
        check_eq("midrst_out_stb", 32'(output_z_stb), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (output_z_stb) seen = 1'b1;
        end
        check_eq("midrst_no_stb", 32'(seen), 32'd0);
        convert(32'd5, 0, res, lat);
        check_eq("after_rst_5", res, 32'h40A0_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
